// File: rtl/memory_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_game_pkg
//  Description : Shared types and helpers for the memory game engine
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_game_pkg;

  // Game variants; encoding 3 is folded onto classic by decode_mode()
  typedef enum logic [1:0] {
    MODE_CLASSIC = 2'd0,
    MODE_TIMED   = 2'd1,
    MODE_REVERSE = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXTEND  = 3'd1,
    S_SHOW    = 3'd2,
    S_GAP     = 3'd3,
    S_COLLECT = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  // Widest LED bank the decoder supports (symbols up to 8 bits)
  localparam int ONEHOT_W = 256;

  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_TIMED;
      2'd2:    return MODE_REVERSE;
      default: return MODE_CLASSIC;
    endcase
  endfunction

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [7:0] s);
    return ONEHOT_W'(1) << s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_game_core_sym_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : sym_lfsr
//  Description : Free-running 32-bit Fibonacci LFSR (taps 32,22,2,1)
//                supplying fresh random symbols
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_lfsr #(
  parameter logic [31:0] SEED  = 32'hABCD1234,
  parameter int          SYM_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [SYM_W-1:0] sym
);

  logic [31:0] lfsr;

  // Shift left every cycle, feedback from taps 32,22,2,1 into bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end

  assign sym = lfsr[SYM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/memory_game_core.sv
`default_nettype none
// ============================================================================
//  Module      : memory_game_core
//  Description : Memory game engine: grows a random symbol sequence, plays it
//                back on one-hot LEDs and checks player input (classic,
//                timed and reverse modes in one FSM)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_game_core
  import memory_game_pkg::*;
#(
  parameter int          SYM_W      = 3,
  parameter int          MAX_LEN    = 32,
  parameter int          SHOW_TICKS = 8,
  parameter int          GAP_TICKS  = 2,
  parameter int          TIME_LIMIT = 64,
  parameter logic [31:0] SEED       = 32'hABCD1234,
  localparam int         LW         = $clog2(MAX_LEN + 1),
  localparam int         NLED       = 2 ** SYM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             abort,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_sym,
  output logic [NLED-1:0]  led,
  output logic             input_en,
  output logic             playing,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    score,
  output logic             game_over,
  output logic             won,
  output logic             time_up
);

  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIME_LIMIT);

  state_t           state, state_n;
  mode_t            mode_r;
  logic [LW-1:0]    len;
  logic [IW-1:0]    idx, k;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic [SYM_W-1:0] mem [MAX_LEN];
  logic [SYM_W-1:0] rnd;
  logic [LW-1:0]    exp_pos;
  logic             last_idx, last_k, match, timeout, show_done, gap_done;

  sym_lfsr #(.SEED(SEED), .SYM_W(SYM_W)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .sym   (rnd)
  );

  assign last_idx  = (LW'(idx) == len - LW'(1));
  assign last_k    = (LW'(k) == len - LW'(1));
  // Reverse mode walks the stored sequence from its newest entry backwards
  assign exp_pos   = (mode_r == MODE_REVERSE) ? (len - LW'(1) - LW'(k)) : LW'(k);
  assign match     = (btn_sym == mem[exp_pos[IW-1:0]]);
  assign timeout   = (mode_r == MODE_TIMED) && (timer == TW'(TIME_LIMIT - 1));
  assign show_done = (cnt == CW'(SHOW_TICKS - 1));
  assign gap_done  = (cnt == CW'(GAP_TICKS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode; a button press wins over a same-cycle timeout
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_OVER: if (start) state_n = S_EXTEND;
      S_EXTEND:       state_n = S_SHOW;
      S_SHOW:         if (show_done) state_n = S_GAP;
      S_GAP:          if (gap_done) state_n = last_idx ? S_COLLECT : S_SHOW;
      S_COLLECT: begin
        if (btn_valid) begin
          if (!match)     state_n = S_OVER;
          else if (last_k) state_n = (len == LW'(MAX_LEN)) ? S_OVER : S_EXTEND;
        end else if (timeout) begin
          state_n = S_OVER;
        end
      end
      default:        state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  // Datapath: sequence memory, length/score, indices, tick and input timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= MODE_CLASSIC;
      len     <= '0;
      score   <= '0;
      idx     <= '0;
      k       <= '0;
      cnt     <= '0;
      timer   <= '0;
      won     <= 1'b0;
      time_up <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else begin
      cnt   <= (state_n == state) ? cnt + CW'(1) : '0;
      timer <= (state == S_COLLECT) ? timer + TW'(1) : '0;
      if (abort) begin
        won     <= 1'b0;
        time_up <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_OVER: begin
            if (start) begin
              mode_r  <= decode_mode(mode);
              len     <= '0;
              score   <= '0;
              won     <= 1'b0;
              time_up <= 1'b0;
            end
          end
          S_EXTEND: begin
            mem[len[IW-1:0]] <= rnd;
            len              <= len + LW'(1);
            idx              <= '0;
          end
          S_GAP: begin
            if (gap_done) begin
              if (last_idx) k   <= '0;
              else          idx <= idx + IW'(1);
            end
          end
          S_COLLECT: begin
            if (btn_valid) begin
              if (match) begin
                if (last_k) begin
                  score <= score + LW'(1);
                  won   <= (len == LW'(MAX_LEN));
                end else begin
                  k <= k + IW'(1);
                end
              end
            end else if (timeout) begin
              time_up <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign led       = (state == S_SHOW) ? NLED'(onehot(8'(mem[idx]))) : '0;
  assign input_en  = (state == S_COLLECT);
  assign playing   = (state == S_EXTEND) || (state == S_SHOW) ||
                     (state == S_GAP) || (state == S_COLLECT);
  assign game_over = (state == S_OVER);
  assign level     = len;

endmodule
`default_nettype wire
